fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit_pc_register.sv | 32 +++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit and control unit: default widths
// and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int PC_WIDTH_DEF = 8;
    localparam int IR_WIDTH_DEF = 16;

    localparam logic [1:0] FSM_IDLE = 2'd0;
    localparam logic [1:0] FSM_REQ  = 2'd1;
    localparam logic [1:0] FSM_WAIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = FSM_IDLE,
        ST_REQ  = FSM_REQ,
        ST_WAIT = FSM_WAIT
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Program-memory read channel between the fetch unit (master) and the
// instruction memory (slave).
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_valid;
    logic [IR_WIDTH-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data
    );
endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter: load has priority over increment; arithmetic wraps
// modulo 2^PC_WIDTH.
module pc_register #(
    parameter int PC_WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [PC_WIDTH-1:0] i_load_value,
    input  logic                i_inc,
    output logic [PC_WIDTH-1:0] o_pc
);
    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [PC_WIDTH-1:0] r_pc;

    // PC state: load wins, all increment sources collapse into a single +1
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_load_value;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_ONE;
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: IDLE/REQ/WAIT sequencer, instruction register and
// flush handling around a pc_register instance.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    input  logic                in_fetch_start,
    input  logic                in_pc_load,
    input  logic [PC_WIDTH-1:0] in_pc_value,
    input  logic                in_pc_inc,
    input  logic                in_pc_enable_out,
    fetch_unit_if.master        imem,
    output logic [IR_WIDTH-1:0] out_ir,
    output logic                out_ir_valid,
    output logic                out_busy,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [PC_WIDTH-1:0] out_pc_bus
);
    fetch_state_e        r_state;
    logic                r_flush;
    logic                r_imem_req;
    logic                r_busy;
    logic                r_ir_valid;
    logic [IR_WIDTH-1:0] r_ir;

    logic                w_discard;
    logic                w_complete;
    logic [PC_WIDTH-1:0] w_pc;

    // A load now or earlier in this fetch makes the in-flight response stale
    assign w_discard  = r_flush | in_pc_load;
    assign w_complete = (r_state == ST_WAIT) & imem.imem_valid & ~w_discard;

    pc_register #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_register (
        .i_clk        (in_clk),
        .i_rst_n      (in_rst_n),
        .i_load       (in_pc_load),
        .i_load_value (in_pc_value),
        .i_inc        (in_pc_inc | w_complete),
        .o_pc         (w_pc)
    );

    // Fetch sequencer with registered request, busy and IR outputs
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state    <= ST_IDLE;
            r_flush    <= 1'b0;
            r_imem_req <= 1'b0;
            r_busy     <= 1'b0;
            r_ir_valid <= 1'b0;
            r_ir       <= '0;
        end else begin
            r_ir_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_fetch_start) begin
                        r_state    <= ST_REQ;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                        r_flush    <= 1'b0;
                    end else begin
                        r_imem_req <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                ST_REQ: begin
                    r_state    <= ST_WAIT;
                    r_imem_req <= 1'b0;
                    r_busy     <= 1'b1;
                    if (in_pc_load) begin
                        r_flush <= 1'b1;
                    end else begin
                        r_flush <= r_flush;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_valid && w_discard) begin
                        r_state    <= ST_REQ;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                        r_flush    <= 1'b0;
                    end else if (imem.imem_valid) begin
                        r_state    <= ST_IDLE;
                        r_imem_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_ir       <= imem.imem_data;
                        r_ir_valid <= 1'b1;
                    end else begin
                        r_imem_req <= 1'b0;
                        r_busy     <= 1'b1;
                        if (in_pc_load) begin
                            r_flush <= 1'b1;
                        end else begin
                            r_flush <= r_flush;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_imem_req <= 1'b0;
                    r_busy     <= 1'b0;
                    r_flush    <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = w_pc;
    assign out_ir         = r_ir;
    assign out_ir_valid   = r_ir_valid;
    assign out_busy       = r_busy;
    assign out_pc         = w_pc;
    assign out_pc_bus     = in_pc_enable_out ? w_pc : {PC_WIDTH{1'b0}};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a transaction-level
// model (program memory array, PC as an integer modulo 256, last IR).
module tb_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        in_fetch_start;
    logic        in_pc_load;
    logic [7:0]  in_pc_value;
    logic        in_pc_inc;
    logic        in_pc_enable_out;
    logic [15:0] out_ir;
    logic        out_ir_valid;
    logic        out_busy;
    logic [7:0]  out_pc;
    logic [7:0]  out_pc_bus;

    int vectors;
    int miscompares;

    logic [15:0] mem [0:255];
    int          m_pc;
    logic [15:0] m_ir;

    fetch_unit_if #(.PC_WIDTH(8), .IR_WIDTH(16)) imem_bus ();

    fetch_unit #(.PC_WIDTH(8), .IR_WIDTH(16)) dut (
        .in_clk           (clk),
        .in_rst_n         (rst_n),
        .in_fetch_start   (in_fetch_start),
        .in_pc_load       (in_pc_load),
        .in_pc_value      (in_pc_value),
        .in_pc_inc        (in_pc_inc),
        .in_pc_enable_out (in_pc_enable_out),
        .imem             (imem_bus),
        .out_ir           (out_ir),
        .out_ir_valid     (out_ir_valid),
        .out_busy         (out_busy),
        .out_pc           (out_pc),
        .out_pc_bus       (out_pc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        in_pc_enable_out = 1'($urandom_range(0, 1));
        #1;
        chk({tag, "_busy"}, 32'(out_busy), 32'd0);
        chk({tag, "_req"}, 32'(imem_bus.imem_req), 32'd0);
        chk({tag, "_pc"}, 32'(out_pc), 32'(m_pc));
        chk({tag, "_ir"}, 32'(out_ir), 32'(m_ir));
        chk({tag, "_pcbus"}, 32'(out_pc_bus), in_pc_enable_out ? 32'(m_pc) : 32'd0);
    endtask

    task automatic respond(input logic [15:0] data);
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_data  = data;
        @(negedge clk);
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_data  = 16'($urandom);
    endtask

    task automatic load_pc(input logic [7:0] v);
        in_pc_load  = 1'b1;
        in_pc_value = v;
        @(negedge clk);
        in_pc_load = 1'b0;
        m_pc = int'(v);
        chk_idle("load");
    endtask

    task automatic fetch(input int delay, input bit inc_mid, input bit start_mid);
        logic [7:0] addr;
        addr = 8'(m_pc);
        in_fetch_start = 1'b1;
        @(negedge clk);
        in_fetch_start = 1'b0;
        chk("req", 32'(imem_bus.imem_req), 32'd1);
        chk("req_addr", 32'(imem_bus.imem_addr), 32'(addr));
        chk("busy_req", 32'(out_busy), 32'd1);
        @(negedge clk);
        chk("req_one_cycle", 32'(imem_bus.imem_req), 32'd0);
        for (int d = 0; d < delay; d++) begin
            in_pc_inc      = inc_mid && (d == 0);
            in_fetch_start = start_mid && (d == 0);
            @(negedge clk);
            in_pc_inc      = 1'b0;
            in_fetch_start = 1'b0;
            if (inc_mid && d == 0) m_pc = (m_pc + 1) % 256;
            chk("wait_busy", 32'(out_busy), 32'd1);
            chk("wait_noreq", 32'(imem_bus.imem_req), 32'd0);
            chk("wait_noirv", 32'(out_ir_valid), 32'd0);
            chk("wait_pc", 32'(out_pc), 32'(m_pc));
        end
        respond(mem[addr]);
        m_pc = (m_pc + 1) % 256;
        m_ir = mem[addr];
        chk("irv_pulse", 32'(out_ir_valid), 32'd1);
        chk("ir_data", 32'(out_ir), 32'(m_ir));
        chk("pc_after", 32'(out_pc), 32'(m_pc));
        chk("busy_done", 32'(out_busy), 32'd0);
        @(negedge clk);
        chk("irv_single", 32'(out_ir_valid), 32'd0);
        chk_idle("post_fetch");
    endtask

    // where: 0 = load during REQ, 1 = load in WAIT before the response, 2 = load with the response
    task automatic fetch_flush(input int where, input logic [7:0] tgt);
        in_fetch_start = 1'b1;
        @(negedge clk);
        in_fetch_start = 1'b0;
        chk("fl_req", 32'(imem_bus.imem_req), 32'd1);
        if (where == 0) begin
            in_pc_load  = 1'b1;
            in_pc_value = tgt;
        end
        @(negedge clk);
        in_pc_load = 1'b0;
        if (where == 0) m_pc = int'(tgt);
        if (where == 1) begin
            in_pc_load  = 1'b1;
            in_pc_value = tgt;
            @(negedge clk);
            in_pc_load = 1'b0;
            m_pc = int'(tgt);
            chk("fl_wait_busy", 32'(out_busy), 32'd1);
        end
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_data  = 16'h1111;
        if (where == 2) begin
            in_pc_load  = 1'b1;
            in_pc_value = tgt;
        end
        @(negedge clk);
        imem_bus.imem_valid = 1'b0;
        in_pc_load = 1'b0;
        m_pc = int'(tgt);
        chk("fl_no_irv", 32'(out_ir_valid), 32'd0);
        chk("fl_ir_held", 32'(out_ir), 32'(m_ir));
        chk("fl_pc", 32'(out_pc), 32'(m_pc));
        chk("fl_refetch", 32'(imem_bus.imem_req), 32'd1);
        chk("fl_addr", 32'(imem_bus.imem_addr), 32'(tgt));
        @(negedge clk);
        chk("fl_req_once", 32'(imem_bus.imem_req), 32'd0);
        respond(mem[tgt]);
        m_ir = mem[tgt];
        m_pc = (m_pc + 1) % 256;
        chk("fl_irv", 32'(out_ir_valid), 32'd1);
        chk("fl_ir", 32'(out_ir), 32'(m_ir));
        chk("fl_pc_done", 32'(out_pc), 32'(m_pc));
        @(negedge clk);
        chk_idle("fl_post");
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst_n            = 1'b0;
        in_fetch_start   = 1'b0;
        in_pc_load       = 1'b0;
        in_pc_value      = 8'h00;
        in_pc_inc        = 1'b0;
        in_pc_enable_out = 1'b0;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_data  = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hA5C3;
        m_pc = 0;
        m_ir = 16'h0000;

        @(negedge clk);
        @(negedge clk);
        chk("rst_irv", 32'(out_ir_valid), 32'd0);
        chk_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // first fetch after reset reads address 0, minimum latency
        fetch(0, 1'b0, 1'b0);

        // wrap at the top of the address space
        load_pc(8'hFF);
        fetch(0, 1'b0, 1'b0);

        // flushes: load in WAIT with stale data, then in REQ, then with the response
        fetch_flush(1, 8'h40);
        fetch_flush(0, 8'($urandom));
        fetch_flush(2, 8'($urandom));

        // slow memory, then a fetch_start during WAIT that must be ignored
        fetch(5, 1'b0, 1'b0);
        fetch(2, 1'b0, 1'b1);

        // load and inc together in IDLE: load wins
        in_pc_load  = 1'b1;
        in_pc_inc   = 1'b1;
        in_pc_value = 8'h10;
        @(negedge clk);
        in_pc_load = 1'b0;
        in_pc_inc  = 1'b0;
        m_pc = 16;
        chk_idle("load_inc");

        // skip in IDLE, response while IDLE ignored, skip during WAIT
        in_pc_inc = 1'b1;
        @(negedge clk);
        in_pc_inc = 1'b0;
        m_pc = (m_pc + 1) % 256;
        chk_idle("inc_idle");
        respond(16'hDEAD);
        chk("idle_valid_irv", 32'(out_ir_valid), 32'd0);
        chk_idle("idle_valid");
        fetch(3, 1'b1, 1'b0);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: fetch(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                1: load_pc(8'($urandom));
                2: begin
                    in_pc_inc = 1'b1;
                    @(negedge clk);
                    in_pc_inc = 1'b0;
                    m_pc = (m_pc + 1) % 256;
                    chk_idle("rnd_inc");
                end
                3: fetch_flush(int'($urandom_range(0, 2)), 8'($urandom));
                default: begin
                    respond(16'($urandom));
                    chk("rnd_idle_irv", 32'(out_ir_valid), 32'd0);
                    chk_idle("rnd_idle_valid");
                end
            endcase
        end

        // reset during WAIT, response arrives after release
        load_pc(8'h33);
        in_fetch_start = 1'b1;
        @(negedge clk);
        in_fetch_start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_pc = 0;
        m_ir = 16'h0000;
        chk("arst_irv", 32'(out_ir_valid), 32'd0);
        chk_idle("arst");
        @(negedge clk);
        rst_n = 1'b1;
        respond(16'hBEEF);
        chk("late_irv", 32'(out_ir_valid), 32'd0);
        chk_idle("late_valid");
        fetch(1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
